// File: rtl/cfg_pkg.sv
// Shared definitions for the tile configuration bus writer.
// Widths here must agree with the tile-side loader.
package cfg_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 9;

  // Tile index that marks end-of-bitstream instead of a real frame.
  localparam logic [7:0] EOB_TILE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TILE = 3'd1,
    ST_AHI  = 3'd2,
    ST_ALO  = 3'd3,
    ST_CNT  = 3'd4,
    ST_DATA = 3'd5,
    ST_GAP  = 3'd6,
    ST_DONE = 3'd7
  } state_t;

  // A count byte of zero stands for a full 256-byte payload.
  function automatic logic [CNT_W-1:0] frame_len(input logic [7:0] cnt_byte);
    if (cnt_byte == 8'd0) begin
      return 9'd256;
    end
    return {1'b0, cnt_byte};
  endfunction

endpackage

// File: rtl/cfg_gap_timer.sv
// Down-counter used to hold off the host for a fixed number of cycles
// after each tile write. Load wins over count; the counter parks at zero.
module cfg_gap_timer #(
  parameter int W = 1
) (
  input  logic         conf,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load on a write, otherwise count down while enabled until zero.
  always_ff @(posedge conf or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cfg_bitstream_writer.sv
// Host byte stream to tile configuration bus.
// Parses SYNC/TILE/ADDR_HI/ADDR_LO/CNT framed payloads and turns each
// payload byte into a one-cycle one-hot tile write strobe.
//
//   state | meaning
//   IDLE  | hunting for the SYNC byte, everything else dropped
//   TILE  | tile index byte expected (EOB_TILE ends the bitstream)
//   AHI   | address bits [9:8] expected
//   ALO   | address bits [7:0] expected
//   CNT   | payload length expected (0 = 256)
//   DATA  | payload bytes, one write each
//   GAP   | host held off after a write (in_ready low)
//   DONE  | bitstream finished, bytes swallowed until reset
module cfg_bitstream_writer
  import cfg_pkg::*;
#(
  parameter int         NB_TILES = 4,
  parameter int         GAP      = 1,
  parameter logic [7:0] SYNC     = 8'hA5
) (
  input  logic                conf,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NB_TILES-1:0] select_tile,
  output logic [ADDR_W-1:0]   address_tile,
  output logic [DATA_W-1:0]   data_tile,
  output logic                busy,
  output logic                cfg_done,
  output logic                err_tile,
  output logic                err_wrap
);

  // The timer is loaded with GAP-1 in the strobe cycle, so the GAP state
  // lasts exactly GAP cycles including that strobe cycle.
  localparam int         GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int         GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [7:0] NB_LIMIT = 8'(NB_TILES);

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic                 data_wr;
  logic                 last_byte;
  logic                 gap_zero;
  logic [7:0]           tile_idx;
  logic                 discard;
  logic [ADDR_W-1:0]    addr;
  logic [CNT_W-1:0]     remaining;
  logic [NB_TILES-1:0]  sel_onehot;

  assign accept    = in_valid && in_ready;
  assign data_wr   = accept && (state == ST_DATA);
  assign last_byte = (remaining == 9'd1);

  cfg_gap_timer #(
    .W (GAP_W)
  ) u_gap_timer (
    .conf     (conf),
    .reset    (reset),
    .load     (data_wr),
    .load_val (GAP_W'(GAP_LOAD)),
    .en       (state == ST_GAP),
    .zero     (gap_zero)
  );

  // State register.
  always_ff @(posedge conf or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; a SYNC byte past IDLE is plain header/payload data.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && (in_data == SYNC)) state_nxt = ST_TILE;
      end
      ST_TILE: begin
        if (accept) state_nxt = (in_data == EOB_TILE) ? ST_DONE : ST_AHI;
      end
      ST_AHI: begin
        if (accept) state_nxt = ST_ALO;
      end
      ST_ALO: begin
        if (accept) state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (accept) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (accept) begin
          if (GAP > 0) begin
            state_nxt = ST_GAP;
          end else if (last_byte) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_zero) state_nxt = (remaining == '0) ? ST_IDLE : ST_DATA;
      end
      ST_DONE: begin
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = (state != ST_GAP);
    busy     = (state != ST_IDLE) && (state != ST_DONE);
    cfg_done = (state == ST_DONE);
  end

  // One-hot decode of the latched tile index.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NB_TILES; i++) begin
      sel_onehot[i] = (tile_idx == 8'(i));
    end
  end

  // Tile index capture; out-of-range tiles turn the frame into a discard.
  always_ff @(posedge conf or posedge reset) begin
    if (reset) begin
      tile_idx <= '0;
      discard  <= 1'b0;
      err_tile <= 1'b0;
    end else if (accept && (state == ST_TILE) && (in_data != EOB_TILE)) begin
      tile_idx <= in_data;
      discard  <= (in_data >= NB_LIMIT);
      if (in_data >= NB_LIMIT) begin
        err_tile <= 1'b1;
      end
    end
  end

  // Write address: loaded from the header, then advanced per payload byte.
  always_ff @(posedge conf or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      err_wrap <= 1'b0;
    end else if (accept) begin
      case (state)
        ST_AHI:  addr[9:8] <= in_data[1:0];
        ST_ALO:  addr[7:0] <= in_data;
        ST_DATA: begin
          addr <= addr + ADDR_W'(1);
          if (addr == '1) begin
            err_wrap <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Payload bytes still to come in the current frame.
  always_ff @(posedge conf or posedge reset) begin
    if (reset) begin
      remaining <= '0;
    end else if (accept && (state == ST_CNT)) begin
      remaining <= frame_len(in_data);
    end else if (data_wr) begin
      remaining <= remaining - 9'd1;
    end
  end

  // Tile bus: strobe for one cycle per written byte, address/data hold.
  always_ff @(posedge conf or posedge reset) begin
    if (reset) begin
      select_tile  <= '0;
      address_tile <= '0;
      data_tile    <= '0;
    end else begin
      select_tile <= '0;
      if (data_wr && !discard) begin
        select_tile  <= sel_onehot;
        address_tile <= addr;
        data_tile    <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_cfg_bitstream_writer.sv
// Scoreboard bench for cfg_bitstream_writer.
// A frame-level parser of the whole byte stream predicts every write and
// the sticky flags; a negedge monitor checks strobes and in_ready.
module tb_cfg_bitstream_writer;

  localparam int         NB   = 4;
  localparam int         G    = 2;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          conf;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] select_tile;
  logic [9:0]    address_tile;
  logic [7:0]    data_tile;
  logic          busy;
  logic          cfg_done;
  logic          err_tile;
  logic          err_wrap;

  cfg_bitstream_writer #(
    .NB_TILES (NB),
    .GAP      (G),
    .SYNC     (SYNC)
  ) dut (
    .conf         (conf),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .select_tile  (select_tile),
    .address_tile (address_tile),
    .data_tile    (data_tile),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .err_tile     (err_tile),
    .err_wrap     (err_wrap)
  );

  initial conf = 1'b0;
  always #5 conf = ~conf;

  int cyc = 0;
  always @(posedge conf) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int            cyc;
    logic [NB-1:0] sel;
    logic [9:0]    addr;
    logic [7:0]    data;
  } wr_t;
  wr_t exp_q[$];

  // Byte stream since the last reset and the per-byte model results.
  logic [7:0]    s      [0:2047];
  bit            wr     [0:2047];
  bit            isdat  [0:2047];
  logic [NB-1:0] e_sel  [0:2047];
  logic [9:0]    e_addr [0:2047];
  logic [7:0]    e_data [0:2047];
  int            n = 0;
  bit            m_done, m_etile, m_ewrap, m_open;
  int            last_data_cyc = -100;
  logic [7:0]    bq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Parse the stream frame by frame with index arithmetic.
  function automatic void model();
    int i, k, a, cnt;
    logic [7:0]    t;
    logic [NB-1:0] one;
    bit            bad;
    one = 1;
    m_done = 0; m_etile = 0; m_ewrap = 0; m_open = 0;
    for (int j = 0; j < n; j++) begin
      wr[j] = 0;
      isdat[j] = 0;
    end
    i = 0;
    while (i < n) begin
      if (m_done || s[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 1 >= n) begin m_open = 1; break; end
      t = s[i+1];
      if (t == 8'hFF) begin
        m_done = 1;
        i += 2;
        continue;
      end
      bad = (int'(t) >= NB);
      if (bad) m_etile = 1;
      if (i + 4 >= n) begin m_open = 1; break; end
      a   = int'({s[i+2][1:0], s[i+3]});
      cnt = (s[i+4] == 8'd0) ? 256 : int'(s[i+4]);
      for (int j = 0; j < cnt; j++) begin
        k = i + 5 + j;
        if (k >= n) begin m_open = 1; break; end
        isdat[k] = 1;
        if (!bad) begin
          wr[k]     = 1;
          e_sel[k]  = one << t;
          e_addr[k] = 10'((a + j) % 1024);
          e_data[k] = s[k];
        end
        if ((a + j) % 1024 == 1023) m_ewrap = 1;
      end
      if (m_open) break;
      i += 5 + cnt;
    end
  endfunction

  // Strobe scoreboard and in_ready check, sampled mid-cycle.
  always @(negedge conf) begin
    wr_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_strobe: got no strobe, expected addr %0h data %0h in cycle %0d", e.addr, e.data, e.cyc);
    end
    if (select_tile != '0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got sel %b addr %0h data %0h, expected no strobe", select_tile, address_tile, data_tile);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("select_tile", select_tile, e.sel);
        chk("address_tile", address_tile, e.addr);
        chk("data_tile", data_tile, e.data);
      end
    end
    chk("in_ready", in_ready, !((cyc >= last_data_cyc) && (cyc < last_data_cyc + G)));
  end

  task automatic send(input int idx, input int idle);
    int waited = 0;
    wr_t e;
    in_valid = 0;
    repeat (idle) begin @(posedge conf); #1; end
    in_data  = s[idx];
    in_valid = 1;
    @(negedge conf);
    while (!in_ready && waited < 20) begin
      @(negedge conf);
      waited++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: byte %0d not accepted, in_ready %b expected 1", idx, in_ready);
      in_valid = 0;
      return;
    end
    @(posedge conf); #1;
    in_valid = 0;
    if (wr[idx]) begin
      e.cyc = cyc; e.sel = e_sel[idx]; e.addr = e_addr[idx]; e.data = e_data[idx];
      exp_q.push_back(e);
    end
    if (isdat[idx]) last_data_cyc = cyc;
  endtask

  task automatic run(input int stall_idx, input int stall_len, input bit rnd);
    int base = n;
    int idle;
    foreach (bq[j]) begin
      s[n] = bq[j];
      n++;
    end
    model();
    for (int j = base; j < n; j++) begin
      idle = 0;
      if (j - base == stall_idx) idle = stall_len;
      else if (rnd && $urandom_range(0, 3) == 0) idle = $urandom_range(1, 3);
      send(j, idle);
    end
  endtask

  task automatic settle();
    in_valid = 0;
    repeat (G + 3) @(posedge conf);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("busy", busy, m_open);
    chk("cfg_done", cfg_done, m_done);
    chk("err_tile", err_tile, m_etile);
    chk("err_wrap", err_wrap, m_ewrap);
  endtask

  task automatic do_reset();
    reset = 1;
    in_valid = 0;
    exp_q.delete();
    n = 0;
    last_data_cyc = -100;
    m_done = 0; m_etile = 0; m_ewrap = 0; m_open = 0;
    repeat (3) @(posedge conf);
    #1;
    reset = 0;
  endtask

  initial begin
    logic [7:0] b;
    reset = 1; in_valid = 0; in_data = 8'h00;
    repeat (2) @(posedge conf);
    #1;
    chk("rst_select", select_tile, 0);
    chk("rst_address", address_tile, 0);
    chk("rst_data", data_tile, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_err_tile", err_tile, 0);
    chk("rst_err_wrap", err_wrap, 0);
    reset = 0;

    // Single write to tile 1 at 0x210.
    bq = {8'hA5, 8'h01, 8'h02, 8'h10, 8'h01, 8'h3C};
    run(-1, 0, 0);
    settle();

    // Three-byte burst crossing 0x0FF -> 0x100.
    bq = {8'hA5, 8'h00, 8'h00, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33};
    run(-1, 0, 0);
    settle();

    // Address wrap 1023 -> 0.
    bq = {8'hA5, 8'h00, 8'h03, 8'hFF, 8'h02, 8'hAA, 8'hBB};
    run(-1, 0, 0);
    settle();

    // Tile 7 does not exist: no strobe, err_tile.
    bq = {8'hA5, 8'h07, 8'h00, 8'h00, 8'h01, 8'hCC};
    run(-1, 0, 0);
    settle();

    // Leading garbage plus a 5-cycle stall before ADDR_LO.
    bq = {8'h00, 8'h5A, 8'hA5, 8'h02, 8'h01, 8'h00, 8'h02, 8'h77, 8'h88};
    run(5, 5, 0);
    settle();

    // Random frames: bad tiles, junk high address bits, SYNC in payload.
    for (int f = 0; f < 30; f++) begin
      bq = {};
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        bq.push_back(b);
      end
      bq.push_back(SYNC);
      bq.push_back(8'($urandom_range(0, 5)));
      bq.push_back(8'($urandom_range(0, 255)));
      bq.push_back(($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 255)));
      bq.push_back(8'($urandom_range(1, 5)));
      for (int d = 0; d < int'(bq[bq.size()-1]); d++) begin
        bq.push_back(($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom_range(0, 255)));
      end
      run(-1, 0, 1);
      if (f % 10 == 9) settle();
    end

    // End of bitstream, then trailing bytes that must be swallowed.
    bq = {8'hA5, 8'hFF, 8'h10, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h55};
    run(-1, 0, 0);
    settle();

    // Reset in the middle of a strobe clears select without a clock edge.
    do_reset();
    bq = {8'hA5, 8'h03, 8'h00, 8'h20, 8'h03, 8'hD1};
    run(-1, 0, 0);
    chk("pre_reset_select", select_tile, 4'b1000);
    reset = 1;
    exp_q.delete();
    last_data_cyc = -100;
    #1;
    chk("async_select_clear", select_tile, 0);
    chk("async_busy_clear", busy, 0);
    do_reset();
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_cfg_done", cfg_done, 0);
    chk("post_reset_err_tile", err_tile, 0);
    chk("post_reset_err_wrap", err_wrap, 0);

    // CNT = 0 means 256 payload bytes at 0x000..0x0FF.
    bq = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int d = 0; d < 256; d++) bq.push_back(8'($urandom_range(0, 255)));
    run(-1, 0, 0);
    settle();
    chk("cnt0_last_address", address_tile, 10'h0FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
